adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_adder_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: three requesters share one registered W-bit adder.
// A round-robin grant is issued in IDLE, the operands are latched on the
// handshake, the sum is registered in ADD, and the owning requester sees
// its result in RESP until it consumes it.
module adder_arbiter #(
    parameter int W    = 16,
    parameter int NREQ = 3
) (
    input  logic              ti_clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W:0]        rsp_sum,
    output logic [1:0]        rsp_id,
    output logic              busy,
    output logic [15:0]       op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Round-robin pick starting at p; result is {found, id[1:0]}.
    function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] p);
        logic [2:0] r;
        r = 3'b000;
        case (p)
            2'd0: begin
                if (v[0])      r = 3'b100;
                else if (v[1]) r = 3'b101;
                else if (v[2]) r = 3'b110;
                else           r = 3'b000;
            end
            2'd1: begin
                if (v[1])      r = 3'b101;
                else if (v[2]) r = 3'b110;
                else if (v[0]) r = 3'b100;
                else           r = 3'b000;
            end
            default: begin
                if (v[2])      r = 3'b110;
                else if (v[0]) r = 3'b100;
                else if (v[1]) r = 3'b101;
                else           r = 3'b000;
            end
        endcase
        return r;
    endfunction

    // Requester index to one-hot strobe.
    function automatic logic [2:0] id_onehot(input logic [1:0] id);
        logic [2:0] r;
        case (id)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            default: r = 3'b100;
        endcase
        return r;
    endfunction

    // (id + 1) mod 3, the search start after requester id is served.
    function automatic logic [1:0] next_ptr(input logic [1:0] id);
        logic [1:0] r;
        case (id)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      id_q, id_d;
    logic [W:0]      sum_q, sum_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]     op_count_q, op_count_d;

    logic [2:0]      pick_s;
    logic [1:0]      grant_id_s;
    logic [NREQ-1:0] req_ready_s;
    logic            handshake_s;
    logic [W-1:0]    a_sel_s;
    logic [W-1:0]    b_sel_s;

    assign pick_s     = rr_pick(req_valid, ptr_q);
    assign grant_id_s = pick_s[1:0];

    // Select the granted requester's operand pair.
    always_comb begin
        a_sel_s = req_a[0 +: W];
        b_sel_s = req_b[0 +: W];
        case (grant_id_s)
            2'd0: begin
                a_sel_s = req_a[0 +: W];
                b_sel_s = req_b[0 +: W];
            end
            2'd1: begin
                a_sel_s = req_a[W +: W];
                b_sel_s = req_b[W +: W];
            end
            default: begin
                a_sel_s = req_a[2*W +: W];
                b_sel_s = req_b[2*W +: W];
            end
        endcase
    end

    // Next-state, grant strobe and datapath updates for the three-state FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        sum_d       = sum_q;
        rsp_valid_d = rsp_valid_q;
        op_count_d  = op_count_q;
        req_ready_s = '0;
        handshake_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Grant only exists while out of reset; no grant memory is kept.
                if (pick_s[2] && rst_n) begin
                    req_ready_s = id_onehot(grant_id_s);
                end else begin
                    req_ready_s = '0;
                end
                handshake_s = |(req_valid & req_ready_s);
                if (handshake_s) begin
                    state_d = S_ADD;
                    a_d     = a_sel_s;
                    b_d     = b_sel_s;
                    id_d    = grant_id_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                // Carry is kept in the extra MSB.
                sum_d       = {1'b0, a_q} + {1'b0, b_q};
                rsp_valid_d = id_onehot(id_q);
                state_d     = S_RESP;
            end
            S_RESP: begin
                // Only the owner's rsp_ready bit can release the result.
                if (rsp_ready[id_q]) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = '0;
                    ptr_d       = next_ptr(id_q);
                    op_count_d  = op_count_q + 16'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 2'd0;
            sum_q       <= '0;
            rsp_valid_q <= '0;
            op_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            sum_q       <= sum_d;
            rsp_valid_q <= rsp_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a transaction-level model (owner, result,
// search start, completed count) tracks the expected outputs; every falling
// edge compares the DUT against it, and directed scenarios add literal checks.
module tb_adder_arbiter;

    localparam int W = 16;

    logic          ti_clk = 1'b0;
    logic          rst_n  = 1'b1;
    logic [2:0]    req_valid = 3'b000;
    logic [2:0]    req_ready;
    logic [3*W-1:0] req_a = '0;
    logic [3*W-1:0] req_b = '0;
    logic [2:0]    rsp_valid;
    logic [2:0]    rsp_ready = 3'b000;
    logic [W:0]    rsp_sum;
    logic [1:0]    rsp_id;
    logic          busy;
    logic [15:0]   op_count;

    int n_cmp = 0;
    int n_bad = 0;

    adder_arbiter #(.W(W), .NREQ(3)) dut (
        .ti_clk   (ti_clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_id   (rsp_id),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 ti_clk = ~ti_clk;

    // First valid requester searching p, p+1, p+2 (mod 3); -1 if none.
    function automatic int pick(input logic [2:0] v, input int p);
        for (int k = 0; k < 3; k++) begin
            if (v[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    // Transaction model: who owns the adder, whether the result is visible,
    // the result itself, where the next search starts, and how many completed.
    int         m_owner  = -1;
    bit         m_shown  = 1'b0;
    logic [W:0] m_sum    = '0;
    int         m_ptr    = 0;
    logic [15:0] m_count = 16'd0;

    // Advance the model one clock, or clear it on reset.
    always @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_shown <= 1'b0;
            m_sum   <= '0;
            m_ptr   <= 0;
            m_count <= 16'd0;
        end else if (m_owner < 0) begin
            if (pick(req_valid, m_ptr) >= 0) begin
                m_owner <= pick(req_valid, m_ptr);
                m_shown <= 1'b0;
                m_sum   <= {1'b0, req_a[pick(req_valid, m_ptr)*W +: W]}
                         + {1'b0, req_b[pick(req_valid, m_ptr)*W +: W]};
            end
        end else if (!m_shown) begin
            m_shown <= 1'b1;
        end else if (rsp_ready[m_owner]) begin
            m_owner <= -1;
            m_shown <= 1'b0;
            m_ptr   <= (m_owner + 1) % 3;
            m_count <= m_count + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compare_all();
        logic [2:0] e_rr;
        logic [2:0] e_rv;
        int g;
        g    = pick(req_valid, m_ptr);
        e_rr = (rst_n && m_owner < 0 && g >= 0) ? 3'(1 << g) : 3'b000;
        e_rv = (m_owner >= 0 && m_shown) ? 3'(1 << m_owner) : 3'b000;
        chk("model_req_ready", 32'(req_ready), 32'(e_rr));
        chk("model_rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("model_busy",      32'(busy),      32'(m_owner >= 0));
        chk("model_op_count",  32'(op_count),  32'(m_count));
        if (e_rv != 3'b000) begin
            chk("model_rsp_sum", 32'(rsp_sum), 32'(m_sum));
            chk("model_rsp_id",  32'(rsp_id),  32'(m_owner));
        end
    endtask

    task automatic cycle();
        @(negedge ti_clk);
        compare_all();
    endtask

    task automatic do_reset();
        req_valid = 3'b000;
        rsp_ready = 3'b000;
        rst_n     = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    // One complete operation on a single requester with immediate consume.
    task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W:0] s);
        int n;
        req_valid = 3'(1 << id);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        rsp_ready = 3'b111;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            cycle();
            #1;
            n++;
        end
        if (n >= 20) chk("op_accept_timeout", 32'd0, 32'd1);
        cycle();
        req_valid = 3'b000;
        n = 0;
        while (rsp_valid == 3'b000 && n < 20) begin
            cycle();
            n++;
        end
        if (n >= 20) chk("op_response_timeout", 32'd0, 32'd1);
        s = rsp_sum;
        cycle();
    endtask

    initial begin
        logic [W:0] s;
        int         order [6];
        int         exp_order [6];
        int         ng;
        exp_order = '{0, 1, 2, 0, 1, 2};

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_op_count",  32'(op_count),  32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_rsp_sum",   32'(rsp_sum),   32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;

        // Requester 1 alone: 0x1234 + 0x0F0F.
        req_valid = 3'b010;
        req_a[W +: W] = 16'h1234;
        req_b[W +: W] = 16'h0F0F;
        rsp_ready = 3'b111;
        #1;
        chk("r1_req_ready", 32'(req_ready), 32'h2);
        cycle();
        chk("r1_busy_add", 32'(busy), 32'd1);
        chk("r1_no_rsp_yet", 32'(rsp_valid), 32'd0);
        req_valid = 3'b000;
        cycle();
        chk("r1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("r1_rsp_sum",   32'(rsp_sum),   32'h02143);
        chk("r1_rsp_id",    32'(rsp_id),    32'd1);
        cycle();
        chk("r1_op_count", 32'(op_count), 32'd1);
        chk("r1_idle",     32'(busy),     32'd0);

        // Carry cases on requester 0.
        do_op(0, 16'hFFFF, 16'h0001, s);
        chk("carry_ffff_1", 32'(s), 32'h10000);
        do_op(0, 16'hFFFF, 16'hFFFF, s);
        chk("carry_ffff_ffff", 32'(s), 32'h1FFFE);
        chk("carry_op_count", 32'(op_count), 32'd3);

        // All three continuously valid: rotation from requester 0.
        do_reset();
        req_valid = 3'b111;
        rsp_ready = 3'b111;
        ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            #1;
            if (req_ready != 3'b000) begin
                order[ng] = (req_ready == 3'b001) ? 0 : (req_ready == 3'b010) ? 1 : 2;
                ng++;
            end
            cycle();
        end
        req_valid = 3'b000;
        if (ng < 6) chk("rotation_timeout", 32'(ng), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < ng) chk("rotation_order", 32'(order[k]), 32'(exp_order[k]));
        end
        repeat (2) cycle();
        chk("rotation_op_count", 32'(op_count), 32'd6);

        // Requester 2 stalls its response; non-owner rsp_ready bits are asserted.
        req_valid = 3'b100;
        req_a[2*W +: W] = 16'h00AA;
        req_b[2*W +: W] = 16'h0055;
        rsp_ready = 3'b011;
        #1;
        chk("stall_grant2", 32'(req_ready), 32'h4);
        cycle();
        req_valid = 3'b001;
        cycle();
        for (int k = 0; k < 10; k++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'h4);
            chk("stall_rsp_sum",   32'(rsp_sum),   32'h000FF);
            chk("stall_rsp_id",    32'(rsp_id),    32'd2);
            chk("stall_busy",      32'(busy),      32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            cycle();
        end
        rsp_ready = 3'b100;
        cycle();
        chk("stall_released", 32'(busy), 32'd0);
        chk("stall_then_r0",  32'(req_ready), 32'h1);
        chk("stall_op_count", 32'(op_count), 32'd7);
        rsp_ready = 3'b111;
        cycle();
        req_valid = 3'b000;
        repeat (2) cycle();

        // Reset pulse during RESP aborts the result.
        req_valid = 3'b010;
        rsp_ready = 3'b000;
        #1;
        cycle();
        req_valid = 3'b000;
        cycle();
        chk("abort_in_resp", 32'(rsp_valid), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_op_count",  32'(op_count),  32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        cycle();
        rst_n = 1'b1;
        req_valid = 3'b110;
        #1;
        chk("abort_next_grant", 32'(req_ready), 32'h2);
        rsp_ready = 3'b111;
        cycle();
        req_valid = 3'b000;
        repeat (3) cycle();

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            req_valid = 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
            req_a = {16'($urandom), 16'($urandom), 16'($urandom)};
            req_b = {16'($urandom), 16'($urandom), 16'($urandom)};
            if ($urandom_range(0, 15) == 0) req_a[0 +: W] = 16'hFFFF;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
